// File: rtl/rvm_mem_access.sv
// Load/store/fetch memory access unit: alignment check, single-outstanding bus access,
// lane steering and load extension. Optional bus timeout under RVM_MEM_TIMEOUT_EN.
module rvm_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_req_valid,
  output logic        ctrl_req_ready,
  input  logic        ctrl_req_write,
  input  logic [31:0] ctrl_req_addr,
  input  logic [1:0]  ctrl_req_size,
  input  logic        ctrl_req_signed,
  input  logic [31:0] ctrl_req_wdata,
  output logic        ctrl_rsp_valid,
  output logic [31:0] ctrl_rsp_rdata,
  output logic        ctrl_rsp_error,
  output logic        ctrl_rsp_misaligned,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } req_t;

  state_t              state_q, state_d;
  req_t                req_q;
  logic                accept_c;
  logic                misaligned_c;
  logic [3:0]          strb_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [DATA_W-1:0]   shifted_c;
  logic [DATA_W-1:0]   load_c;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                rsp_error_d;
  logic                rsp_mis_d;
  logic                timeout_c;

  assign ctrl_req_ready = (state_q == IDLE) && !reset;
  assign accept_c       = ctrl_req_valid && ctrl_req_ready;

  // Alignment check on the incoming request
  always_comb begin
    misaligned_c = 1'b0;
    case (ctrl_req_size)
      2'b01:   misaligned_c = ctrl_req_addr[0];
      2'b10:   misaligned_c = |ctrl_req_addr[1:0];
      2'b11:   misaligned_c = 1'b1;
      default: misaligned_c = 1'b0;
    endcase
  end

  // Byte strobes and lane-replicated store data
  always_comb begin
    strb_c  = 4'b1111;
    wdata_c = ctrl_req_wdata;
    case (ctrl_req_size)
      2'b00: begin
        strb_c  = 4'b0001 << ctrl_req_addr[1:0];
        wdata_c = {4{ctrl_req_wdata[7:0]}};
      end
      2'b01: begin
        strb_c  = 4'b0011 << {ctrl_req_addr[1], 1'b0};
        wdata_c = {2{ctrl_req_wdata[15:0]}};
      end
      default: begin
        strb_c  = 4'b1111;
        wdata_c = ctrl_req_wdata;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of load data
  always_comb begin
    shifted_c = mem_rdata >> {req_q.off, 3'b000};
    load_c    = shifted_c;
    case (req_q.size)
      2'b00:   load_c = req_q.sgn ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                                  : {24'd0, shifted_c[7:0]};
      2'b01:   load_c = req_q.sgn ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                                  : {16'd0, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

`ifdef RVM_MEM_TIMEOUT_EN
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             busy_c;

  assign busy_c    = (state_q == REQ) || (state_q == WAIT);
  assign timeout_c = busy_c && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Saturates at the limit so a grant landing on the limit still times out in WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (!busy_c) begin
      tmo_cnt_q <= '0;
    end else if (!timeout_c) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
  assign timeout_c            = 1'b0;
`endif

  // Next-state and response payload
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;
    rsp_mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (misaligned_c) begin
            state_d   = RESP;
            rsp_mis_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = WAIT;
        end else if (timeout_c) begin
          state_d     = RESP;
          rsp_error_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d     = RESP;
          rsp_error_d = mem_error;
          rsp_rdata_d = (mem_error || req_q.write) ? '0 : load_c;
        end else if (timeout_c) begin
          state_d     = RESP;
          rsp_error_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered bus and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q               <= '0;
      mem_req             <= 1'b0;
      mem_wen             <= 1'b0;
      mem_addr            <= '0;
      mem_strb            <= '0;
      mem_wdata           <= '0;
      ctrl_rsp_valid      <= 1'b0;
      ctrl_rsp_rdata      <= '0;
      ctrl_rsp_error      <= 1'b0;
      ctrl_rsp_misaligned <= 1'b0;
    end else begin
      mem_req             <= (state_d == REQ);
      ctrl_rsp_valid      <= (state_d == RESP);
      ctrl_rsp_rdata      <= rsp_rdata_d;
      ctrl_rsp_error      <= rsp_error_d;
      ctrl_rsp_misaligned <= rsp_mis_d;
      if (accept_c) begin
        req_q <= '{write: ctrl_req_write, size: ctrl_req_size,
                   sgn: ctrl_req_signed, off: ctrl_req_addr[1:0]};
        if (!misaligned_c) begin
          mem_wen   <= ctrl_req_write;
          mem_addr  <= {ctrl_req_addr[31:2], 2'b00};
          mem_strb  <= strb_c;
          mem_wdata <= wdata_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_rvm_mem_access.sv
// Directed bench for rvm_mem_access; timeout scenario runs when RVM_MEM_TIMEOUT_EN is defined.
module tb_rvm_mem_access;

  logic        clk;
  logic        reset;
  logic        ctrl_req_valid;
  logic        ctrl_req_ready;
  logic        ctrl_req_write;
  logic [31:0] ctrl_req_addr;
  logic [1:0]  ctrl_req_size;
  logic        ctrl_req_signed;
  logic [31:0] ctrl_req_wdata;
  logic        ctrl_rsp_valid;
  logic [31:0] ctrl_rsp_rdata;
  logic        ctrl_rsp_error;
  logic        ctrl_rsp_misaligned;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        mem_error;

  int checks;
  int failures;

  rvm_mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ctrl_req_valid      (ctrl_req_valid),
    .ctrl_req_ready      (ctrl_req_ready),
    .ctrl_req_write      (ctrl_req_write),
    .ctrl_req_addr       (ctrl_req_addr),
    .ctrl_req_size       (ctrl_req_size),
    .ctrl_req_signed     (ctrl_req_signed),
    .ctrl_req_wdata      (ctrl_req_wdata),
    .ctrl_rsp_valid      (ctrl_rsp_valid),
    .ctrl_rsp_rdata      (ctrl_rsp_rdata),
    .ctrl_rsp_error      (ctrl_rsp_error),
    .ctrl_rsp_misaligned (ctrl_rsp_misaligned),
    .mem_req             (mem_req),
    .mem_gnt             (mem_gnt),
    .mem_wen             (mem_wen),
    .mem_addr            (mem_addr),
    .mem_strb            (mem_strb),
    .mem_wdata           (mem_wdata),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rdata           (mem_rdata),
    .mem_error           (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata);
    ctrl_req_valid  = 1'b1;
    ctrl_req_write  = wr;
    ctrl_req_addr   = addr;
    ctrl_req_size   = size;
    ctrl_req_signed = sgn;
    ctrl_req_wdata  = wdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0 || ctrl_rsp_valid !== 1'b0 || mem_strb !== 4'h0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: mem_req=%b rsp_valid=%b strb=%h addr=%h, want 0 0 0 0",
               mem_req, ctrl_rsp_valid, mem_strb, mem_addr);
    end
    checks++;
    if (ctrl_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_low: got %b want 0", ctrl_req_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ctrl_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_high: got %b want 1", ctrl_req_ready);
    end
    step();
  endtask

  task automatic test_signed_byte_load();
    issue(1'b0, 32'h0000_1003, 2'b00, 1'b1, 32'h0);
    step();
    ctrl_req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_strb !== 4'b1000 || mem_wen !== 1'b0) begin
      failures++;
      $display("FAIL sbyte_bus: req=%b addr=%h strb=%b wen=%b, want 1 00001000 1000 0",
               mem_req, mem_addr, mem_strb, mem_wen);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL sbyte_req_drop: got %b want 0", mem_req);
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h80FF_FFFF;
    step();
    mem_rsp_valid = 1'b0;
    checks++;
    if (ctrl_rsp_valid !== 1'b1 || ctrl_rsp_rdata !== 32'hFFFF_FF80 || ctrl_rsp_error !== 1'b0 ||
        ctrl_rsp_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL sbyte_rsp: valid=%b rdata=%h err=%b mis=%b, want 1 ffffff80 0 0",
               ctrl_rsp_valid, ctrl_rsp_rdata, ctrl_rsp_error, ctrl_rsp_misaligned);
    end
    step();
    checks++;
    if (ctrl_rsp_valid !== 1'b0 || ctrl_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL sbyte_pulse: valid=%b ready=%b, want 0 1", ctrl_rsp_valid, ctrl_req_ready);
    end
  endtask

  task automatic test_half_load();
    issue(1'b0, 32'h0000_0012, 2'b01, 1'b0, 32'h0);
    step();
    ctrl_req_valid = 1'b0;
    checks++;
    if (mem_strb !== 4'b1100 || mem_addr !== 32'h0000_0010) begin
      failures++;
      $display("FAIL uhalf_bus: strb=%b addr=%h, want 1100 00000010", mem_strb, mem_addr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt       = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h8123_4567;
    step();
    mem_rsp_valid = 1'b0;
    checks++;
    if (ctrl_rsp_valid !== 1'b1 || ctrl_rsp_rdata !== 32'h0000_8123) begin
      failures++;
      $display("FAIL uhalf_rsp: valid=%b rdata=%h, want 1 00008123", ctrl_rsp_valid, ctrl_rsp_rdata);
    end
    step();
  endtask

  task automatic test_half_store();
    issue(1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h0000_BEEF);
    step();
    ctrl_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 32'h0000_2000 ||
          mem_strb !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF) begin
        failures++;
        $display("FAIL hstore_stall%0d: req=%b wen=%b addr=%h strb=%b wdata=%h, want 1 1 00002000 1100 beefbeef",
                 i, mem_req, mem_wen, mem_addr, mem_strb, mem_wdata);
      end
      if (i == 3) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL hstore_req_drop: got %b want 0", mem_req);
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1234_5678;
    step();
    mem_rsp_valid = 1'b0;
    checks++;
    if (ctrl_rsp_valid !== 1'b1 || ctrl_rsp_rdata !== 32'h0 || ctrl_rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL hstore_rsp: valid=%b rdata=%h err=%b, want 1 00000000 0",
               ctrl_rsp_valid, ctrl_rsp_rdata, ctrl_rsp_error);
    end
    step();
  endtask

  task automatic test_byte_store();
    issue(1'b1, 32'h0000_5001, 2'b00, 1'b0, 32'h1234_56AB);
    step();
    ctrl_req_valid = 1'b0;
    checks++;
    if (mem_wdata !== 32'hABAB_ABAB || mem_strb !== 4'b0010 || mem_addr !== 32'h0000_5000) begin
      failures++;
      $display("FAIL bstore_bus: wdata=%h strb=%b addr=%h, want abababab 0010 00005000",
               mem_wdata, mem_strb, mem_addr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt       = 1'b0;
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    step();
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2];
    logic [1:0]  sizes [2];
    addrs[0] = 32'h0000_0001; sizes[0] = 2'b10;
    addrs[1] = 32'h0000_0004; sizes[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, addrs[k], sizes[k], 1'b0, 32'h0);
      step();
      ctrl_req_valid = 1'b0;
      checks++;
      if (ctrl_rsp_valid !== 1'b1 || ctrl_rsp_misaligned !== 1'b1 || mem_req !== 1'b0 ||
          ctrl_rsp_rdata !== 32'h0 || ctrl_rsp_error !== 1'b0) begin
        failures++;
        $display("FAIL misaligned%0d_rsp: valid=%b mis=%b req=%b rdata=%h err=%b, want 1 1 0 0 0",
                 k, ctrl_rsp_valid, ctrl_rsp_misaligned, mem_req, ctrl_rsp_rdata, ctrl_rsp_error);
      end
      step();
      checks++;
      if (ctrl_rsp_valid !== 1'b0 || mem_req !== 1'b0 || ctrl_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL misaligned%0d_after: valid=%b req=%b ready=%b, want 0 0 1",
                 k, ctrl_rsp_valid, mem_req, ctrl_req_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'h0000_3000, 2'b10, 1'b0, 32'h0);
    step();
    ctrl_req_valid = 1'b0;
    mem_gnt        = 1'b1;
    checks++;
    if (mem_strb !== 4'b1111) begin
      failures++;
      $display("FAIL berr_strb: got %b want 1111", mem_strb);
    end
    step();
    mem_gnt       = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_error     = 1'b1;
    mem_rdata     = 32'hDEAD_BEEF;
    step();
    mem_rsp_valid = 1'b0;
    mem_error     = 1'b0;
    checks++;
    if (ctrl_rsp_valid !== 1'b1 || ctrl_rsp_error !== 1'b1 || ctrl_rsp_rdata !== 32'h0 ||
        ctrl_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL berr_rsp: valid=%b err=%b rdata=%h ready=%b, want 1 1 00000000 0",
               ctrl_rsp_valid, ctrl_rsp_error, ctrl_rsp_rdata, ctrl_req_ready);
    end
    issue(1'b0, 32'h0000_3004, 2'b10, 1'b0, 32'h0);
    step();
    checks++;
    if (ctrl_req_ready !== 1'b1 || mem_req !== 1'b0 || ctrl_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: ready=%b req=%b valid=%b, want 1 0 0",
               ctrl_req_ready, mem_req, ctrl_rsp_valid);
    end
    step();
    ctrl_req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3004) begin
      failures++;
      $display("FAIL b2b_req: req=%b addr=%h, want 1 00003004", mem_req, mem_addr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt       = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hA5A5_1234;
    step();
    mem_rsp_valid = 1'b0;
    checks++;
    if (ctrl_rsp_valid !== 1'b1 || ctrl_rsp_rdata !== 32'hA5A5_1234 || ctrl_rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rsp: valid=%b rdata=%h err=%b, want 1 a5a51234 0",
               ctrl_rsp_valid, ctrl_rsp_rdata, ctrl_rsp_error);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    issue(1'b0, 32'h0000_4000, 2'b10, 1'b0, 32'h0);
    step();
    ctrl_req_valid = 1'b0;
    mem_gnt        = 1'b1;
    step();
    mem_gnt = 1'b0;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || ctrl_rsp_valid !== 1'b0 || ctrl_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_state: req=%b valid=%b ready=%b, want 0 0 1",
               mem_req, ctrl_rsp_valid, ctrl_req_ready);
    end
    step();
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hFFFF_FFFF;
    step();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ctrl_rsp_valid !== 1'b0 || mem_req !== 1'b0 || ctrl_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL rst_late_rsp%0d: valid=%b req=%b ready=%b, want 0 0 1",
                 i, ctrl_rsp_valid, mem_req, ctrl_req_ready);
      end
      step();
    end
  endtask

`ifdef RVM_MEM_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    seen = 1'b0;
    issue(1'b0, 32'h0000_6000, 2'b10, 1'b0, 32'h0);
    step();
    ctrl_req_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (ctrl_rsp_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (ctrl_rsp_error !== 1'b1 || ctrl_rsp_rdata !== 32'h0 || mem_req !== 1'b0) begin
          failures++;
          $display("FAIL timeout_rsp: err=%b rdata=%h req=%b, want 1 00000000 0",
                   ctrl_rsp_error, ctrl_rsp_rdata, mem_req);
        end
      end
      step();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL timeout_seen: no response within 20 cycles, want one");
    end
    checks++;
    if (mem_req !== 1'b0 || ctrl_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_after: req=%b ready=%b, want 0 1", mem_req, ctrl_req_ready);
    end
  endtask
`endif

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    ctrl_req_valid  = 1'b0;
    ctrl_req_write  = 1'b0;
    ctrl_req_addr   = '0;
    ctrl_req_size   = '0;
    ctrl_req_signed = 1'b0;
    ctrl_req_wdata  = '0;
    mem_gnt         = 1'b0;
    mem_rsp_valid   = 1'b0;
    mem_rdata       = '0;
    mem_error       = 1'b0;

    test_reset();
    test_signed_byte_load();
    test_half_load();
    test_half_store();
    test_byte_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_op();
`ifdef RVM_MEM_TIMEOUT_EN
    test_timeout();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
